if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the core_lapido pipeline. It is the producer end of the IF/ID interface.
- Holds the PC and issues word-addressed fetches to instruction memory over a req/ack handshake.
- Registers each fetched instruction and its PC into the IF/ID pipeline register that feeds the decode stage.
- Redirects on jumps from ID and on taken branches from MEM. Holds under hazard stall and flushes on a taken branch.

Parameters:
- PC_WIDTH, 32, PC and memory address width; word addressing, PC increments by 1.
- INSTRUCTION_WIDTH, 32, instruction word width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- stall_pipeline  in  1  hazard unit stall; hold IF/ID and PC.
- is_jump  in  1  unconditional jump decoded in ID.
- jump_addr  in  PC_WIDTH  jump target from ID.
- branch_taken  in  1  taken branch resolved in MEM.
- branch_addr  in  PC_WIDTH  branch target from MEM.
- imem_req  out  1  fetch request, registered level.
- imem_addr  out  PC_WIDTH  fetch address, registered.
- imem_ack  in  1  one-cycle pulse, imem_rdata valid.
- imem_rdata  in  INSTRUCTION_WIDTH  fetched word.
- out_instruction  out  INSTRUCTION_WIDTH  IF/ID instruction; 0 = nop/bubble.
- out_pc  out  PC_WIDTH  address of out_instruction.
- out_valid  out  1  out_instruction is a real fetched instruction.

Behaviour:
- Reset values: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, out_instruction=0, out_pc=0, out_valid=0, hold buffer empty, redirect target cleared.
- Memory protocol:
  - imem_addr is stable while imem_req=1.
  - Ack may arrive in any cycle with imem_req=1, including the first (combinational memory), and at most one ack per request.
  - Ack while imem_req=0 is ignored.
- Redirect: branch_taken has priority over is_jump. Target is branch_addr, else jump_addr. is_jump is ignored while stall_pipeline=1; branch_taken acts regardless.
- IF/ID register update each edge, in priority order:
  - branch_taken: flush, out_instruction=0, out_valid=0, out_pc held.
  - else stall_pipeline: hold.
  - else is_jump: bubble, out_instruction=0, out_valid=0.
  - else deliver from ack or HOLD buffer if available: out_instruction=word, out_pc=its address, out_valid=1.
  - else bubble.
- FSM states:
  - IDLE:
    - req=0.
    - If a redirect is pending: pc=target, then behave as below.
    - If not stalled: req<=1, addr<=pc, go to WAIT.
  - WAIT:
    - req=1.
    - Redirect without ack: latch target, go to DRAIN; req stays 1, same addr.
    - Redirect with ack: drop word; req<=1, addr<=target, pc<=target+1, stay in WAIT.
    - Ack with stall: store word+addr in HOLD buffer, pc<=addr+1, req<=0, go to HOLD.
    - Ack with no stall: deliver, addr<=addr+1, pc<=addr+2, stay in WAIT (back-to-back: 1 instr/cycle with 0-latency memory).
    - No ack: wait; IF/ID gets a bubble if not stalled.
  - DRAIN:
    - req=1 with the old addr.
    - A new redirect overwrites the latched target.
    - On ack: drop word; addr<=target, go to WAIT.
  - HOLD:
    - req=0.
    - Redirect: discard buffer; addr<=target, req<=1, go to WAIT.
    - !stall: deliver buffer; req<=1, addr<=pc, go to WAIT.
- Invariant: no instruction is duplicated or skipped on the sequential path; no wrong-path instruction reaches IF/ID with out_valid=1.
- PC arithmetic wraps modulo 2^PC_WIDTH.
- Reset mid-transaction: everything returns to reset values immediately. Memory is reset by the same rst, so no stale ack is expected; any ack in IDLE is ignored.

Test Plan:
- 0-latency memory, rdata=0x1000+addr, RESET_PC=0 -> imem_addr 0,1,2,… every cycle; out_pc 0,1,2 and out_instruction 0x1000,0x1001,0x1002 on consecutive cycles, out_valid=1.
- 3-cycle ack latency, stall_pipeline high on ack of addr 5 for 4 cycles -> HOLD; out_pc/out_instruction stay at previous values; after release out_pc=5, then addr 6 requested; no loss or duplication.
- is_jump=1, jump_addr=0x40 while fetch of addr 7 is outstanding (ack 2 cycles later) -> DRAIN; addr 7 word dropped; next imem_addr=0x40; out_valid=0 until word 0x40 is delivered.
- branch_taken with branch_addr=0x80 and is_jump with jump_addr=0x40 in the same cycle -> next request at 0x80; out_instruction=0, out_valid=0.
- branch_taken=1 while stall_pipeline=1 -> flush wins; out_instruction=0 next cycle; fetch resumes at branch_addr once the stall clears.
- rst pulse mid-WAIT at addr 0x12 -> imem_req=0 and all outputs 0 asynchronously; after release, first request is at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage of the core_lapido pipeline.
// Holds the PC, fetches word-addressed instructions over a req/ack handshake
// and fills the IF/ID pipeline register feeding decode. Handles jump/branch
// redirects, hazard stalls and branch flushes.
module if_stage #(
  parameter int                     PC_WIDTH          = 32,
  parameter int                     INSTRUCTION_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall_pipeline,
  input  logic                         is_jump,
  input  logic [PC_WIDTH-1:0]          jump_addr,
  input  logic                         branch_taken,
  input  logic [PC_WIDTH-1:0]          branch_addr,
  output logic                         imem_req,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic                         imem_ack,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic                         out_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_HOLD} state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0] PC_TWO = PC_WIDTH'(2);

  state_t                         state, state_n;
  logic [PC_WIDTH-1:0]            pc, pc_n;
  logic [PC_WIDTH-1:0]            redir_tgt, redir_tgt_n;
  logic [INSTRUCTION_WIDTH-1:0]   hold_instr, hold_instr_n;
  logic [PC_WIDTH-1:0]            hold_pc, hold_pc_n;
  logic                           req_n;
  logic [PC_WIDTH-1:0]            addr_n;
  logic [INSTRUCTION_WIDTH-1:0]   out_instruction_n;
  logic [PC_WIDTH-1:0]            out_pc_n;
  logic                           out_valid_n;

  logic                           ack;
  logic                           redirect;
  logic [PC_WIDTH-1:0]            target;
  logic [PC_WIDTH-1:0]            fetch_pc;
  logic [PC_WIDTH-1:0]            drain_tgt;
  logic                           deliver;
  logic [INSTRUCTION_WIDTH-1:0]   deliver_instr;
  logic [PC_WIDTH-1:0]            deliver_pc;

  // An ack only counts while a request is actually outstanding.
  assign ack      = imem_ack & imem_req;
  // A jump is only honoured when ID is not stalled; a branch from MEM always wins.
  assign redirect = branch_taken | (is_jump & ~stall_pipeline);
  assign target   = branch_taken ? branch_addr : jump_addr;

  // Next-state, fetch-port and IF/ID register computation.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n           = state;
    pc_n              = pc;
    redir_tgt_n       = redir_tgt;
    hold_instr_n      = hold_instr;
    hold_pc_n         = hold_pc;
    req_n             = imem_req;
    addr_n            = imem_addr;
    out_instruction_n = out_instruction;
    out_pc_n          = out_pc;
    out_valid_n       = out_valid;
    deliver           = 1'b0;
    deliver_instr     = '0;
    deliver_pc        = '0;
    fetch_pc          = redirect ? target : pc;
    drain_tgt         = redirect ? target : redir_tgt;

    unique case (state)
      S_IDLE: begin
        req_n = 1'b0;
        pc_n  = fetch_pc;
        if (!stall_pipeline) begin
          req_n   = 1'b1;
          addr_n  = fetch_pc;
          pc_n    = fetch_pc + PC_ONE;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect && !ack) begin
          // The in-flight word is wrong-path; keep the request up until it lands.
          redir_tgt_n = target;
          state_n     = S_DRAIN;
        end else if (redirect) begin
          addr_n = target;
          pc_n   = target + PC_ONE;
        end else if (ack && stall_pipeline) begin
          hold_instr_n = imem_rdata;
          hold_pc_n    = imem_addr;
          pc_n         = imem_addr + PC_ONE;
          req_n        = 1'b0;
          state_n      = S_HOLD;
        end else if (ack) begin
          deliver       = 1'b1;
          deliver_instr = imem_rdata;
          deliver_pc    = imem_addr;
          addr_n        = imem_addr + PC_ONE;
          pc_n          = imem_addr + PC_TWO;
        end
      end
      S_DRAIN: begin
        if (redirect) redir_tgt_n = target;
        if (ack) begin
          addr_n  = drain_tgt;
          pc_n    = drain_tgt + PC_ONE;
          state_n = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          req_n   = 1'b1;
          addr_n  = target;
          pc_n    = target + PC_ONE;
          state_n = S_WAIT;
        end else if (!stall_pipeline) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr;
          deliver_pc    = hold_pc;
          req_n         = 1'b1;
          addr_n        = pc;
          pc_n          = pc + PC_ONE;
          state_n       = S_WAIT;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (branch_taken) begin
      out_instruction_n = '0;
      out_valid_n       = 1'b0;
    end else if (stall_pipeline) begin
      out_instruction_n = out_instruction;
    end else if (is_jump) begin
      out_instruction_n = '0;
      out_valid_n       = 1'b0;
    end else if (deliver) begin
      out_instruction_n = deliver_instr;
      out_pc_n          = deliver_pc;
      out_valid_n       = 1'b1;
    end else begin
      out_instruction_n = '0;
      out_valid_n       = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the hold buffer is a couple of registers, not a RAM, so clearing it on reset is free and keeps X out of the datapath.
      state           <= S_IDLE;
      pc              <= RESET_PC;
      redir_tgt       <= '0;
      hold_instr      <= '0;
      hold_pc         <= '0;
      imem_req        <= 1'b0;
      imem_addr       <= '0;
      out_instruction <= '0;
      out_pc          <= '0;
      out_valid       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state           <= state_n;
      pc              <= pc_n;
      redir_tgt       <= redir_tgt_n;
      hold_instr      <= hold_instr_n;
      hold_pc         <= hold_pc_n;
      imem_req        <= req_n;
      imem_addr       <= addr_n;
      out_instruction <= out_instruction_n;
      out_pc          <= out_pc_n;
      out_valid       <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a memory model with programmable ack
// latency, a scoreboard of expected IF/ID deliveries and directed scenarios.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_pipeline = 1'b0;
  logic        is_jump = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_valid;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          lat = 0;
  int          cnt;
  logic        last_stall;

  if_stage #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_pipeline(stall_pipeline),
    .is_jump(is_jump), .jump_addr(jump_addr),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_instruction(out_instruction), .out_pc(out_pc), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Memory model: one ack per request, lat cycles after the request appears.
  assign imem_ack   = imem_req && (cnt == lat);
  assign imem_rdata = 32'h0000_1000 + imem_addr;

  always @(posedge clk or posedge rst) begin
    if (rst)           cnt <= 0;
    else if (imem_ack) cnt <= 0;
    else if (imem_req) cnt <= cnt + 1;
    else               cnt <= 0;
  end

  always @(posedge clk) last_stall <= stall_pipeline;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = 32'h0000_1000 + pc;
    sb_q.push_back(e);
  endtask

  // Monitor: every fresh delivery into IF/ID must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && !last_stall) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_extra: got pc 0x%0h, expected no delivery", out_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instruction, e.instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    stall_pipeline = 1'b0;
    is_jump        = 1'b0;
    branch_taken   = 1'b0;
    jump_addr      = '0;
    branch_addr    = '0;
    repeat (2) tick();
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", out_instruction, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    rst = 1'b0;
  endtask

  task automatic sb_empty(input string name);
    @(negedge clk);
    #1;
    check(name, sb_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;

    // 1: zero-latency memory streams one instruction per cycle.
    lat = 0;
    do_reset();
    for (int i = 0; i < 5; i++) push(i);
    tick();
    check("t1_req", {31'b0, imem_req}, 32'h1);
    check("t1_addr0", imem_addr, 32'h0);
    check("t1_valid0", {31'b0, out_valid}, 32'h0);
    tick();
    check("t1_addr1", imem_addr, 32'h1);
    check("t1_outpc0", out_pc, 32'h0);
    check("t1_instr0", out_instruction, 32'h1000);
    tick();
    check("t1_addr2", imem_addr, 32'h2);
    check("t1_outpc1", out_pc, 32'h1);
    repeat (3) tick();
    stall_pipeline = 1'b1;
    tick();
    check("t1_hold_req", {31'b0, imem_req}, 32'h0);
    check("t1_hold_pc", out_pc, 32'h4);
    sb_empty("t1_sb_empty");

    // 2: 3-cycle latency, stall lands on the ack of addr 5.
    lat = 3;
    do_reset();
    for (int i = 0; i < 7; i++) push(i);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (imem_req && imem_addr == 32'h5 && imem_ack) begin
        found = 1'b1;
        break;
      end
    end
    check("t2_reach5", {31'b0, found}, 32'h1);
    stall_pipeline = 1'b1;
    tick();
    check("t2_hold_req", {31'b0, imem_req}, 32'h0);
    check("t2_hold_outpc", out_pc, 32'h4);
    check("t2_hold_valid", {31'b0, out_valid}, 32'h0);
    repeat (3) tick();
    check("t2_hold_outpc_end", out_pc, 32'h4);
    check("t2_hold_instr_end", out_instruction, 32'h0);
    stall_pipeline = 1'b0;
    tick();
    check("t2_rel_pc", out_pc, 32'h5);
    check("t2_rel_instr", out_instruction, 32'h1005);
    check("t2_rel_valid", {31'b0, out_valid}, 32'h1);
    check("t2_rel_addr", imem_addr, 32'h6);
    check("t2_rel_req", {31'b0, imem_req}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) break;
    end
    check("t2_next_pc", out_pc, 32'h6);
    sb_empty("t2_sb_empty");

    // 3: jump while fetch of addr 7 is outstanding drains the wrong-path word.
    do_reset();
    for (int i = 0; i < 7; i++) push(i);
    push(32'h40);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (imem_req && imem_addr == 32'h7 && cnt == 1) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_reach7", {31'b0, found}, 32'h1);
    is_jump   = 1'b1;
    jump_addr = 32'h40;
    tick();
    is_jump = 1'b0;
    check("t3_drain_addr", imem_addr, 32'h7);
    check("t3_drain_req", {31'b0, imem_req}, 32'h1);
    check("t3_drain_valid", {31'b0, out_valid}, 32'h0);
    tick();
    check("t3_drain_addr2", imem_addr, 32'h7);
    tick();
    check("t3_new_addr", imem_addr, 32'h40);
    check("t3_new_valid", {31'b0, out_valid}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) break;
    end
    check("t3_tgt_pc", out_pc, 32'h40);
    check("t3_tgt_valid", {31'b0, out_valid}, 32'h1);
    sb_empty("t3_sb_empty");

    // 4: branch and jump in the same cycle, branch wins.
    lat = 0;
    do_reset();
    for (int i = 0; i < 3; i++) push(i);
    push(32'h80);
    repeat (4) tick();
    check("t4_pre_pc", out_pc, 32'h2);
    branch_taken = 1'b1;
    branch_addr  = 32'h80;
    is_jump      = 1'b1;
    jump_addr    = 32'h40;
    tick();
    branch_taken = 1'b0;
    is_jump      = 1'b0;
    check("t4_addr", imem_addr, 32'h80);
    check("t4_instr", out_instruction, 32'h0);
    check("t4_valid", {31'b0, out_valid}, 32'h0);
    tick();
    check("t4_del_pc", out_pc, 32'h80);
    stall_pipeline = 1'b1;
    tick();
    sb_empty("t4_sb_empty");

    // 5: branch during stall flushes; fetch resumes at target after release.
    do_reset();
    push(0);
    push(1);
    push(32'h90);
    repeat (3) tick();
    stall_pipeline = 1'b1;
    tick();
    check("t5_stall_valid", {31'b0, out_valid}, 32'h1);
    branch_taken = 1'b1;
    branch_addr  = 32'h90;
    tick();
    branch_taken = 1'b0;
    check("t5_flush_instr", out_instruction, 32'h0);
    check("t5_flush_valid", {31'b0, out_valid}, 32'h0);
    check("t5_flush_addr", imem_addr, 32'h90);
    repeat (2) tick();
    stall_pipeline = 1'b0;
    tick();
    check("t5_res_pc", out_pc, 32'h90);
    check("t5_res_instr", out_instruction, 32'h1090);
    check("t5_res_addr", imem_addr, 32'h91);
    stall_pipeline = 1'b1;
    tick();
    sb_empty("t5_sb_empty");

    // 6: asynchronous reset in the middle of a fetch at 0x12.
    lat = 3;
    do_reset();
    tick();
    is_jump   = 1'b1;
    jump_addr = 32'h12;
    tick();
    is_jump = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_req && imem_addr == 32'h12) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reach12", {31'b0, found}, 32'h1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_req", {31'b0, imem_req}, 32'h0);
    check("t6_async_addr", imem_addr, 32'h0);
    check("t6_async_instr", out_instruction, 32'h0);
    check("t6_async_pc", out_pc, 32'h0);
    check("t6_async_valid", {31'b0, out_valid}, 32'h0);
    do_reset();
    tick();
    check("t6_restart_req", {31'b0, imem_req}, 32'h1);
    check("t6_restart_addr", imem_addr, 32'h0);
    sb_empty("t6_sb_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
